// File: rtl/sprite_render_pkg.sv
// Shared sprite constants: sheet geometry, ROM address width and colour key.
package sprite_render_pkg;

    localparam int         SHEET_W     = 64;
    localparam int         SHEET_H     = 64;
    localparam int         ROM_AW      = 12;
    localparam logic [7:0] KEY_DEFAULT = 8'hE3;

    // Row-major sheet address: upper six bits select the row, lower six the column.
    function automatic logic [ROM_AW-1:0] sheet_addr(input logic [5:0] row,
                                                     input logic [5:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/sprite_render.sv
// Sprite renderer: maps the scan position onto a scaled sprite frame in an
// external 64x64 RGB332 sheet ROM and flags opaque pixels, three clocks later.
module sprite_render
    import sprite_render_pkg::*;
#(
    parameter int         SPR_W      = 16,
    parameter int         SPR_H      = 16,
    parameter int         SCALE_LOG2 = 1,
    parameter logic [7:0] KEY        = KEY_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    input  logic              pix_valid,
    input  logic              frame_start,
    input  logic [8:0]        hoffset,
    input  logic [8:0]        voffset,
    input  logic [9:0]        xpos,
    input  logic [9:0]        ypos,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        sprite_px,
    output logic              sprite_hit
);

    // On-screen box extent, kept 11 bits wide so boxes near column 1023 do not wrap.
    localparam logic [10:0] DW = 11'(SPR_W << SCALE_LOG2);
    localparam logic [10:0] DH = 11'(SPR_H << SCALE_LOG2);

    logic [5:0]  ho_l;
    logic [5:0]  vo_l;
    logic [9:0]  x_l;
    logic [9:0]  y_l;
    logic [10:0] x_end;
    logic [10:0] y_end;
    logic        in_box;
    logic [9:0]  dx;
    logic [9:0]  dy;
    logic [9:0]  dx_s;
    logic [9:0]  dy_s;
    logic [5:0]  col;
    logic [5:0]  row;
    logic        box_d1;
    logic        box_d2;
    logic        unused_bits;

    // Only the low six offset bits address the 64-wide sheet; the rest are dropped.
    assign unused_bits = ^{hoffset[8:6], voffset[8:6], dx_s[9:6], dy_s[9:6]};

    assign x_end  = {1'b0, x_l} + DW;
    assign y_end  = {1'b0, y_l} + DH;
    assign in_box = pix_valid
                  && (hcount >= x_l) && ({1'b0, hcount} < x_end)
                  && (vcount >= y_l) && ({1'b0, vcount} < y_end);

    assign dx   = hcount - x_l;
    assign dy   = vcount - y_l;
    assign dx_s = dx >> SCALE_LOG2;
    assign dy_s = dy >> SCALE_LOG2;
    assign col  = dx_s[5:0];
    assign row  = dy_s[5:0];

    // Shadow registers: capture placement only at frame start so a frame never tears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ho_l <= '0;
            vo_l <= '0;
            x_l  <= '0;
            y_l  <= '0;
        end else if (frame_start) begin
            ho_l <= hoffset[5:0];
            vo_l <= voffset[5:0];
            x_l  <= xpos;
            y_l  <= ypos;
        end
    end

    // Stage 1: issue the sheet address; hold it outside the box to avoid toggling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr <= '0;
            box_d1   <= 1'b0;
        end else begin
            box_d1 <= in_box;
            if (in_box) begin
                rom_addr <= sheet_addr(vo_l + row, ho_l + col);
            end
        end
    end

    // Stage 2: box flag waits while the ROM reads the stage-1 address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            box_d2 <= 1'b0;
        end else begin
            box_d2 <= box_d1;
        end
    end

    // Stage 3: register the pixel and mark it opaque unless it matches the key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sprite_px  <= 8'h00;
            sprite_hit <= 1'b0;
        end else begin
            sprite_px  <= box_d2 ? rom_data : 8'h00;
            sprite_hit <= box_d2 && (rom_data != KEY);
        end
    end

endmodule

// File: tb/tb_sprite_render.sv
// Directed bench for sprite_render with a one-cycle synchronous ROM model.
module tb_sprite_render;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        pix_valid;
    logic        frame_start;
    logic [8:0]  hoffset;
    logic [8:0]  voffset;
    logic [9:0]  xpos;
    logic [9:0]  ypos;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  sprite_px;
    logic        sprite_hit;

    logic [7:0]  rom [4096];

    int compared   = 0;
    int mismatched = 0;

    sprite_render dut (
        .clk        (clk),
        .rst        (rst),
        .hcount     (hcount),
        .vcount     (vcount),
        .pix_valid  (pix_valid),
        .frame_start(frame_start),
        .hoffset    (hoffset),
        .voffset    (voffset),
        .xpos       (xpos),
        .ypos       (ypos),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .sprite_px  (sprite_px),
        .sprite_hit (sprite_hit)
    );

    always #5 clk = ~clk;

    // Sheet ROM: data for an address appears one clock after it is presented.
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_frame(input logic [9:0] xp, input logic [9:0] yp,
                              input logic [8:0] ho, input logic [8:0] vo);
        xpos = xp; ypos = yp; hoffset = ho; voffset = vo;
        pix_valid = 1'b0;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic pixel(input string tag, input logic [9:0] h, input logic [9:0] v,
                         input logic [11:0] ea, input logic [7:0] epx, input logic eh);
        hcount = h; vcount = v; pix_valid = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_addr"}, rom_addr, ea);
        pix_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk({tag, "_px"}, {4'h0, sprite_px}, {4'h0, epx});
        chk({tag, "_hit"}, {11'h0, sprite_hit}, {11'h0, eh});
    endtask

    initial begin
        logic e1, e2, e3, e_now;
        logic [9:0] h;
        int nhits;

        for (int i = 0; i < 4096; i++) rom[i] = 8'h42;
        rom[129]  = 8'hA5;
        rom[2193] = 8'h1C;

        rst = 1'b1; hcount = '0; vcount = '0; pix_valid = 1'b0; frame_start = 1'b0;
        hoffset = '0; voffset = '0; xpos = '0; ypos = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_addr", rom_addr, 12'd0);
        chk("rst_px", {4'h0, sprite_px}, 12'd0);
        chk("rst_hit", {11'h0, sprite_hit}, 12'd0);
        rst = 1'b0;

        // Shadows cleared by reset: sprite at origin with zero offsets.
        pixel("origin", 10'd3, 10'd5, 12'd129, 8'hA5, 1'b1);

        load_frame(10'd100, 10'd50, 9'd16, 9'd32);
        pixel("main", 10'd103, 10'd55, 12'd2193, 8'h1C, 1'b1);

        rom[2193] = 8'hE3;
        pixel("key", 10'd103, 10'd55, 12'd2193, 8'hE3, 1'b0);
        pixel("left_out", 10'd99, 10'd55, 12'd2193, 8'h00, 1'b0);
        pixel("right_out", 10'd132, 10'd55, 12'd2193, 8'h00, 1'b0);
        pixel("right_in", 10'd131, 10'd55, 12'd2207, 8'h42, 1'b1);
        pixel("top_out", 10'd103, 10'd49, 12'd2207, 8'h00, 1'b0);
        pixel("bot_in", 10'd100, 10'd81, 12'd3024, 8'h42, 1'b1);
        pixel("bot_out", 10'd100, 10'd82, 12'd3024, 8'h00, 1'b0);

        // Offset change without frame_start must not take effect.
        rom[2193] = 8'h1C;
        voffset = 9'd48;
        pixel("no_tear", 10'd103, 10'd55, 12'd2193, 8'h1C, 1'b1);
        load_frame(10'd100, 10'd50, 9'd16, 9'd48);
        pixel("new_off", 10'd103, 10'd55, 12'd3217, 8'h42, 1'b1);

        // frame_start coincident with an in-box pixel uses the old shadows.
        voffset = 9'd0; hcount = 10'd103; vcount = 10'd55; pix_valid = 1'b1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        chk("fs_same_addr", rom_addr, 12'd3217);
        frame_start = 1'b0;
        @(posedge clk); #1;
        chk("fs_next_addr", rom_addr, 12'd145);
        pix_valid = 1'b0;

        // Upper offset bits are ignored.
        load_frame(10'd100, 10'd50, 9'h1D0, 9'h1E0);
        pixel("hi_bits", 10'd103, 10'd55, 12'd2193, 8'h1C, 1'b1);

        // Right edge: only columns 630..639 of the line may hit.
        load_frame(10'd630, 10'd0, 9'd0, 9'd0);
        repeat (3) @(posedge clk);
        #1;
        e1 = 1'b0; e2 = 1'b0; e3 = 1'b0; nhits = 0;
        for (int n = 0; n < 223; n++) begin
            if (n < 200) begin
                h = 10'(600 + n); vcount = 10'd0;
            end else begin
                h = 10'(n - 200); vcount = 10'd1;
            end
            hcount = h;
            pix_valid = (n < 221) && (h < 10'd640);
            e_now = pix_valid && (h >= 10'd630);
            @(posedge clk); #1;
            e3 = e2; e2 = e1; e1 = e_now;
            if (sprite_hit) nhits++;
            chk($sformatf("line_hit_n%0d", n), {11'h0, sprite_hit}, {11'h0, e3});
        end
        pix_valid = 1'b0;
        chk("line_hit_count", 12'(nhits), 12'd10);

        // Box reaching past column 1023 must not wrap its right bound.
        load_frame(10'd1000, 10'd0, 9'd0, 9'd0);
        pixel("no_wrap", 10'd1010, 10'd0, 12'd5, 8'h42, 1'b1);
        pixel("wrap_low", 10'd4, 10'd0, 12'd5, 8'h00, 1'b0);

        // Asynchronous reset mid-line clears outputs without a clock edge.
        hcount = 10'd1010; vcount = 10'd2; pix_valid = 1'b1;
        @(posedge clk); #1;
        pix_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("pre_rst_hit", {11'h0, sprite_hit}, 12'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_addr", rom_addr, 12'd0);
        chk("async_rst_px", {4'h0, sprite_px}, 12'd0);
        chk("async_rst_hit", {11'h0, sprite_hit}, 12'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sprite_render.md
SPRITE_RENDER -- requirements
Module: sprite_render

Interface
REQ-001 Parameter SPR_W, default 16, sprite frame width in sheet pixels.
REQ-002 Parameter SPR_H, default 16, sprite frame height in sheet pixels.
REQ-003 Parameter SCALE_LOG2, default 1, on-screen magnification is 2^SCALE_LOG2 per axis.
REQ-004 Parameter KEY, default 8'hE3, RGB332 transparent colour key.
REQ-005 clk  in  1  system clock; the only clock; all state updates on posedge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 hcount  in  10  current video column.
REQ-008 vcount  in  10  current video row.
REQ-009 pix_valid  in  1  hcount/vcount are inside the active video area.
REQ-010 frame_start  in  1  one-cycle pulse at the start of vertical blanking.
REQ-011 hoffset  in  9  sprite-sheet column of the frame to draw, from the sprite selector.
REQ-012 voffset  in  9  sprite-sheet row of the frame to draw, from the sprite selector.
REQ-013 xpos  in  10  screen column of the sprite's top-left corner.
REQ-014 ypos  in  10  screen row of the sprite's top-left corner.
REQ-015 rom_addr  out  12  sprite-sheet ROM address, registered.
REQ-016 rom_data  in  8  RGB332 ROM output, valid exactly one cycle after rom_addr changes.
REQ-017 sprite_px  out  8  sprite pixel colour, registered.
REQ-018 sprite_hit  out  1  sprite_px is opaque and shall be drawn over the background.

Function
REQ-019 Sheet geometry: 64 x 64 pixels, row-major; rom_addr = {sheet_row[5:0], sheet_col[5:0]}, wraps modulo 4096.
REQ-020 Shadow registers ho_l, vo_l, x_l, y_l load hoffset, voffset, xpos, ypos on any clk edge with frame_start=1; they hold at all other times, so offset changes never tear a frame.
REQ-021 Box extent: DW = SPR_W<<SCALE_LOG2, DH = SPR_H<<SCALE_LOG2; all bound compares use 11-bit unsigned arithmetic, so x_l+DW above 1023 does not wrap.
REQ-022 in_box = pix_valid & (hcount >= x_l) & (hcount < x_l+DW) & (vcount >= y_l) & (vcount < y_l+DH).
REQ-023 col = (hcount-x_l)>>SCALE_LOG2 and row = (vcount-y_l)>>SCALE_LOG2, truncated to 6 bits.
REQ-024 Stage 1 (edge t+1): rom_addr <= {vo_l[5:0]+row, ho_l[5:0]+col}; in_box is registered as box_d1.
REQ-025 When in_box=0, rom_addr shall hold its previous value (no toggling outside the sprite).
REQ-026 Stage 2 (edge t+2): box_d1 is registered as box_d2; rom_data becomes valid for the stage-1 address.
REQ-027 Stage 3 (edge t+3): sprite_px <= box_d2 ? rom_data : 8'h00; sprite_hit <= box_d2 & (rom_data != KEY).
REQ-028 Total latency: sprite_hit/sprite_px correspond to the hcount/vcount sampled exactly 3 clocks earlier; throughput is one pixel per clock with no stalls.
REQ-029 Sprite partially off-screen (x_l+DW > 640 or y_l+DH > 480): visible part drawn, remainder never hits because pix_valid=0.
REQ-030 frame_start coincident with an in-box pixel: that pixel uses pre-update shadow values; the new values apply from the next cycle.
REQ-031 hoffset/voffset bits [8:6] are ignored.

Reset
REQ-032 While rst=1: rom_addr=0, sprite_px=0, sprite_hit=0, box_d1=box_d2=0, shadow registers=0, all asynchronously.
REQ-033 After rst deasserts mid-frame, a sprite at origin (0,0) with offsets (0,0) is drawn until the next frame_start loads live values.

Structure
REQ-034 SHEET_W=64, SHEET_H=64, ROM address width 12 and the RGB332 KEY default shall live in the shared sprite constants package used by the sprite selector.
REQ-035 The block shall be a single module; the sprite ROM shall stay external, with no sub-module.

Verification
REQ-036 rst pulse mid-line -> rom_addr, sprite_px and sprite_hit read 0 in the same cycle, with no clock edge needed.
REQ-037 frame_start with xpos=100, ypos=50, hoffset=16, voffset=32, SCALE_LOG2=1; then hcount=103, vcount=55, pix_valid=1 -> rom_addr=2193 one clock later.
REQ-038 Same setup, ROM model returns 8'h1C for address 2193 -> sprite_px=8'h1C and sprite_hit=1 three clocks after the pixel is sampled.
REQ-039 ROM model returns 8'hE3 -> sprite_hit=0 and sprite_px=8'hE3; hcount=99 or 132 -> sprite_hit=0 and sprite_px=0.
REQ-040 Change voffset 32->48 mid-frame without frame_start -> rom_addr is unchanged for the rest of the frame; after the next frame_start the same pixel gives rom_addr=3217.
REQ-041 xpos=630, full scan line -> hits only for hcount 630..639; no hit when hcount wraps to 0.
